// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline,
// owning the EX multi-cycle counter and the MEM bus-wait timeout counter.
module pipeline_hazard_ctrl #(
    parameter int MC_CNT_WIDTH  = 6,
    parameter int MEM_TIMEOUT   = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_stall_req,
    input  logic                    ex_mc_start,
    input  logic [MC_CNT_WIDTH-1:0] ex_mc_cycles,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    input  logic                    exc_req,
    input  logic [31:0]             exc_vector,
    output logic                    stall_pc,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    stall_ex,
    output logic                    stall_mem,
    output logic                    stall_wb,
    output logic                    flush,
    output logic [31:0]             flush_pc,
    output logic                    ex_mc_busy,
    output logic                    bus_error
);
    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;
    state_t state, state_next;
    logic [MC_CNT_WIDTH-1:0] mc_cnt, mc_next;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt, wait_next;
    logic [31:0] vec;
    logic in_flush, mc_load, busy, mem_wait, timeout, mem_stall, run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mc_cnt   <= '0;
            wait_cnt <= '0;
            vec      <= '0;
        end else begin
            state    <= state_next;
            mc_cnt   <= mc_next;
            wait_cnt <= wait_next;
            if (state == IDLE && exc_req) vec <= exc_vector;
        end
    end

    // Outputs are gated by rst so an asserted reset forces them low without a clock edge.
    always_comb begin
        in_flush   = state == FLUSH;
        state_next = state == IDLE ? (exc_req ? FLUSH : IDLE) : in_flush ? DRAIN : IDLE;
        mc_load    = ex_mc_start && mc_cnt == '0 && !in_flush && ex_mc_cycles >= MC_CNT_WIDTH'(2);
        busy       = !in_flush && (mc_cnt != '0 || mc_load);
        mem_wait   = mem_req && !mem_ready;
        timeout    = !in_flush && mem_wait && wait_cnt == TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);
        mem_stall  = !in_flush && mem_wait && !timeout;
        mc_next    = in_flush ? '0 : mc_load ? ex_mc_cycles - MC_CNT_WIDTH'(1) :
                     mc_cnt != '0 ? mc_cnt - MC_CNT_WIDTH'(1) : mc_cnt;
        wait_next  = mem_stall ? wait_cnt + TIMEOUT_WIDTH'(1) : '0;
        run        = rst && state == IDLE;
        stall_pc   = run && (id_stall_req || busy || mem_stall);
        stall_if   = stall_pc;
        stall_id   = stall_pc;
        stall_ex   = run && (busy || mem_stall);
        stall_mem  = run && mem_stall;
        stall_wb   = 1'b0;
        flush      = rst && in_flush;
        flush_pc   = flush ? vec : 32'd0;
        ex_mc_busy = rst && busy;
        bus_error  = rst && timeout;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against a cycle-level
// reference model; expectations are queued and checked by a negedge monitor.
module tb_pipeline_hazard_ctrl;
    localparam int W  = 6;
    localparam int TO = 4;
    localparam int TW = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic id_stall_req = 0, ex_mc_start = 0, mem_req = 0, mem_ready = 0, exc_req = 0;
    logic [W-1:0] ex_mc_cycles = '0;
    logic [31:0] exc_vector = '0;
    logic stall_pc, stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush, ex_mc_busy, bus_error;
    logic [31:0] flush_pc;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MC_CNT_WIDTH(W), .MEM_TIMEOUT(TO), .TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .id_stall_req(id_stall_req), .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles), .mem_req(mem_req), .mem_ready(mem_ready),
        .exc_req(exc_req), .exc_vector(exc_vector), .stall_pc(stall_pc), .stall_if(stall_if),
        .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .flush(flush), .flush_pc(flush_pc), .ex_mc_busy(ex_mc_busy), .bus_error(bus_error)
    );

    logic [40:0] q[$];
    int checks = 0, fails = 0;
    int t = 0, phase = 0, mc_end = 0, run_len = 0;
    logic [31:0] mvec = '0;

    function automatic logic [40:0] actual();
        return {stall_pc, stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush, ex_mc_busy, bus_error, flush_pc};
    endfunction

    always @(negedge clk) begin
        logic [40:0] e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (actual() !== e) begin
                fails++;
                $display("FAIL outputs cycle %0d: got %h expected %h", t, actual(), e);
            end
        end
    end

    // Model: phase 0 idle, 1 flush, 2 drain; EX busy until cycle mc_end; run_len counts stalled wait cycles.
    task automatic step(input logic i, input logic s, input int n, input logic rq, input logic rd,
                        input logic e, input logic [31:0] v);
        logic acc, busy, wt, to, ms;
        int lvl;
        id_stall_req = i; ex_mc_start = s; ex_mc_cycles = W'(n);
        mem_req = rq; mem_ready = rd; exc_req = e; exc_vector = v;
        acc  = s && t >= mc_end && phase != 1;
        busy = phase != 1 && (t < mc_end || (acc && n >= 2));
        wt   = rq && !rd;
        to   = phase != 1 && wt && run_len == TO - 1;
        ms   = phase != 1 && wt && !to;
        lvl  = phase != 0 ? 0 : ms ? 3 : busy ? 2 : i ? 1 : 0;
        q.push_back({lvl >= 1, lvl >= 1, lvl >= 1, lvl >= 2, lvl >= 3, 1'b0, phase == 1, busy, to,
                     phase == 1 ? mvec : 32'd0});
        @(posedge clk);
        if (phase == 1) begin
            mc_end = 0;
            run_len = 0;
        end else begin
            if (acc && n >= 2) mc_end = t + n;
            run_len = ms ? run_len + 1 : 0;
        end
        if (phase == 0 && e) mvec = v;
        phase = phase == 0 ? (e ? 1 : 0) : phase == 1 ? 2 : 0;
        t++;
        #1;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2;
        checks++;
        if (actual() !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h expected 0", actual());
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 9, 0, 0, 0, 0);
        idle(5);
        for (int j = 0; j < 3; j++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        idle(1);
        for (int j = 0; j < 7; j++) step(0, 0, 0, 1, 0, 0, 0);
        idle(1);
        step(0, 1, 10, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hBFC00380);
        idle(3);
        for (int j = 0; j < 5; j++) step(0, 0, 0, 0, 0, 1, 32'h8000_0180 + 32'(j));
        idle(2);
        id_stall_req = 1'b1;
        ex_mc_start = 1'b1;
        ex_mc_cycles = W'(7);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (actual() !== '0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0", actual());
        end
        @(posedge clk) #1;
        id_stall_req = 0; ex_mc_start = 0; ex_mc_cycles = '0;
        phase = 0; mc_end = 0; run_len = 0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        t++;
        idle(1);
        for (int j = 0; j < 3000; j++)
            step($urandom % 4 == 0, $urandom % 8 == 0, int'($urandom % 8), $urandom % 3 != 0,
                 $urandom % 3 == 0, $urandom % 25 == 0, $urandom);
        idle(2);
        @(negedge clk) #1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Collects stall requests from ID (load-use), EX (multi-cycle ALU ops) and MEM (bus wait), plus exceptions from MEM.
- Drives the per-stage stall pair consumed by every inter-stage register (IFID, IDEX, EXMEM, MEMWB) and the PC, and sequences pipeline flushes.
- Owns the multi-cycle EX cycle counter and the MEM bus-wait timeout counter.

Parameters:
MC_CNT_WIDTH, 6, width of the EX multi-cycle length field and counter
MEM_TIMEOUT, 255, max cycles of MEM bus wait before bus_error; must be ≥1
TIMEOUT_WIDTH, 8, width of the MEM wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  reset
id_stall_req  in  1  load-use hazard in ID, level
ex_mc_start  in  1  EX multi-cycle op begins, one-cycle pulse
ex_mc_cycles  in  MC_CNT_WIDTH  total EX cycles of the op, sampled with ex_mc_start
mem_req  in  1  MEM stage bus access outstanding, level
mem_ready  in  1  bus acknowledges access this cycle
exc_req  in  1  exception raised in MEM, level while pending
exc_vector  in  32  handler address, sampled with exc_req
stall_pc  out  1  hold PC
stall_if  out  1  hold IFID
stall_id  out  1  hold IDEX
stall_ex  out  1  hold EXMEM
stall_mem  out  1  hold MEMWB
stall_wb  out  1  always 0; reserved
flush  out  1  clear IFID/IDEX/EXMEM contents
flush_pc  out  32  PC load value, valid while flush=1
ex_mc_busy  out  1  multi-cycle op in progress
bus_error  out  1  one-cycle pulse on MEM wait timeout

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (port rst). On reset assertion all outputs go to 0 immediately; flush_pc=0; FSM=IDLE; both counters cleared.
- Stall level L (0..4): stall_pc..stage L all 1, stages above L 0. A register with stall_current=1 and stall_next=0 emits a bubble. Combinational from inputs and registered state, same-cycle.
  - ID request gives L=ID (stall_pc, stall_if, stall_id).
  - EX busy gives L=EX.
  - MEM wait gives L=MEM.
  - The highest active level wins.
- EX multi-cycle:
  - ex_mc_start with ex_mc_cycles=N≥2 loads counter with N-1 next edge, and ex_mc_busy=1 that same cycle (combinational on start).
  - Counter decrements each cycle; busy=1 while counter≠0.
  - N=0 or 1 means no stall.
  - ex_mc_start while busy is ignored.
- MEM wait:
  - Active when mem_req=1 and mem_ready=0.
  - The wait counter increments each wait cycle and clears when mem_ready=1 or mem_req=0.
  - When the counter reaches MEM_TIMEOUT, that cycle MEM stall is dropped and bus_error=1 for exactly one cycle; the counter clears.
- Flush FSM: IDLE, FLUSH, DRAIN.
  - IDLE: exc_req=1 → FLUSH next edge; exc_vector is latched.
  - FLUSH (1 cycle): flush=1, flush_pc=latched vector, all stalls 0. The EX multi-cycle counter and MEM wait counter are cleared. → DRAIN.
  - DRAIN (1 cycle): stalls 0, flush=0. exc_req is ignored. → IDLE.
  - exc_req during FLUSH/DRAIN is ignored. A still-asserted exc_req in IDLE after DRAIN starts a new flush.
- Simultaneous events:
  - exc_req in IDLE has no effect on stalls in that cycle; the flush follows next cycle.
  - ex_mc_start in the same cycle as the FLUSH state is ignored.
- Reset mid-operation aborts everything; there is no residual stall after rst deasserts.

Test Plan:
1. Reset with all inputs 0 → all stall/flush outputs 0, flush_pc=0; rst asserted mid-stall → outputs 0 without a clock edge.
2. id_stall_req=1 for 1 cycle → stall_pc/if/id=1 that cycle only, stall_ex/mem=0.
3. ex_mc_start with ex_mc_cycles=5 → ex_mc_busy and stall_pc..stall_ex=1 for exactly 5 cycles starting at the pulse. Concurrent id_stall_req does not extend it. A second start at cycle 2 is ignored.
4. mem_req=1, mem_ready=0 for 3 cycles then ready → stall_pc..stall_mem=1 for 3 cycles, then 0, no bus_error. With MEM_TIMEOUT=4 and never ready → stall for 3 cycles, then 4th cycle stall=0 with bus_error pulse.
5. exc_req with exc_vector=0xBFC00380 during an EX multi-cycle op (busy) → next cycle flush=1, flush_pc=0xBFC00380, all stalls 0, busy cleared; following cycle flush=0.
6. exc_req held high 4 cycles → flush pulses at cycle 1 and again at cycle 4 (IDLE, FLUSH, DRAIN, IDLE→FLUSH), never back-to-back.
